// File: rtl/ram_pl_loader.sv
// ram_pl_loader: burst load/readback master driving the RAM macro program-load port
module ram_pl_loader #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 12
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_RD,
  input  logic [ADDR_W-1:0] CMD_ADDR,
  input  logic [LEN_W-1:0]  CMD_LEN,
  input  logic              WR_VALID,
  output logic              WR_READY,
  input  logic [DATA_W-1:0] WR_DATA,
  output logic              RD_VALID,
  input  logic              RD_READY,
  output logic [DATA_W-1:0] RD_DATA,
  output logic              BUSY,
  output logic              DONE,
  output logic              PL_INIT,
  output logic              PL_ENA,
  output logic              PL_WEN,
  output logic              PL_REN,
  output logic [ADDR_W-1:0] PL_ADDR,
  output logic [DATA_W-1:0] PL_DATA_IN,
  input  logic [DATA_W-1:0] PL_DATA_OUT
);
  typedef enum logic [2:0] {IDLE, SETUP, WRITE, READ, DRAIN, FINISH} state_t;
  state_t            state;
  logic              dir, act, head, ren_d, wen_q, wr_hs, pop;
  logic [1:0]        occ;
  logic [ADDR_W-1:0] cur, wr_addr;
  logic [LEN_W-1:0]  rem;
  logic [DATA_W-1:0] din_q;
  logic [DATA_W-1:0] fifo_q [2];
  assign CMD_READY  = state == IDLE && !RST;
  assign WR_READY   = !dir && rem != '0 && (state == SETUP || state == WRITE);
  assign wr_hs      = WR_VALID && WR_READY;
  assign RD_VALID   = occ != 2'd0;
  assign pop        = RD_VALID && RD_READY;
  assign RD_DATA    = RD_VALID ? fifo_q[head] : '0;
  assign PL_REN     = state == READ && rem != '0 && ({1'b0, occ} + {2'b0, ren_d} < 3'd2 + {2'b0, pop});
  assign PL_WEN     = wen_q;
  assign PL_ADDR    = PL_REN ? cur : wr_addr;
  assign PL_DATA_IN = din_q;
  assign BUSY       = state != IDLE;
  assign DONE       = state == FINISH;
  assign PL_ENA     = act && state != IDLE;
  assign PL_INIT    = PL_ENA && !dir;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      dir     <= 1'b0;
      act     <= 1'b0;
      head    <= 1'b0;
      ren_d   <= 1'b0;
      wen_q   <= 1'b0;
      occ     <= 2'd0;
      cur     <= '0;
      wr_addr <= '0;
      rem     <= '0;
      din_q   <= '0;
      fifo_q  <= '{default: '0};
    end else begin
      wen_q <= wr_hs;
      ren_d <= PL_REN;
      if (wr_hs) begin
        wr_addr <= cur;
        din_q   <= WR_DATA;
      end
      if (wr_hs || PL_REN) begin
        cur <= cur + ADDR_W'(1);
        rem <= rem - LEN_W'(1);
      end
      if (ren_d) fifo_q[head ^ occ[0]] <= PL_DATA_OUT;
      if (pop) head <= ~head;
      occ <= occ + {1'b0, ren_d} - {1'b0, pop};
      case (state)
        IDLE: if (CMD_VALID) begin
          dir   <= CMD_RD;
          cur   <= CMD_ADDR;
          rem   <= CMD_LEN;
          act   <= CMD_LEN != '0;
          state <= CMD_LEN == '0 ? FINISH : SETUP;
        end
        SETUP:   state <= dir ? READ : WRITE;
        WRITE:   if (rem == '0) state <= FINISH;
        READ:    if (PL_REN && rem == LEN_W'(1)) state <= DRAIN;
        DRAIN:   if (!ren_d && occ == {1'b0, pop}) state <= FINISH;
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
